// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, data port and memory-side signals of the memory port arbiter.
// The slave modport is the arbiter's view; the master modport is the CPU/memory environment.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, if_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_addr, mem_we, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares a single-ported word memory between instruction fetch and data ports.
// Data wins contention unless fetch has been denied STARVE_LIMIT cycles in a row.
module mem_port_arbiter #(
  parameter int DEPTH        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  mem_port_arbiter_if.slave bus
);
  localparam int            CW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);
  localparam logic [29:0]   DEPTH_W    = 30'(DEPTH);

  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOAD, OWN_STORE} owner_e;

  owner_e        owner_q, owner_d;
  logic          err_q, err_d;
  logic [CW-1:0] starve_q, starve_d;

  logic          ifGnt, dGnt, ifOor, dOor, starved;
  logic [31:0]   memAddr, memWdata;
  logic          memWe;

  assign ifOor   = (bus.if_addr[31:2] >= DEPTH_W);
  assign dOor    = (bus.d_addr[31:2] >= DEPTH_W);
  assign starved = (starve_q == STARVE_MAX);
  assign ifGnt   = bus.if_req & (~bus.d_req | starved);
  assign dGnt    = bus.d_req & ~ifGnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      owner_q  <= OWN_NONE;
      err_q    <= 1'b0;
      starve_q <= '0;
    end else begin
      owner_q  <= owner_d;
      err_q    <= err_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    owner_d  = OWN_NONE;
    err_d    = 1'b0;
    starve_d = starve_q;
    memAddr  = '0;
    memWe    = 1'b0;
    memWdata = '0;

    if (!bus.if_req || ifGnt) begin
      starve_d = '0;
    end else if (!starved) begin
      starve_d = starve_q + CW'(1);
    end

    if (ifGnt) begin
      owner_d = OWN_FETCH;
      err_d   = ifOor;
      memAddr = bus.if_addr;
    end else if (dGnt) begin
      owner_d = bus.d_we ? OWN_STORE : OWN_LOAD;
      err_d   = dOor;
      memAddr = bus.d_addr;
      // Out-of-range stores still present the address but never strobe the write.
      if (bus.d_we && !dOor) begin
        memWe    = 1'b1;
        memWdata = bus.d_wdata;
      end
    end
  end

  assign bus.if_gnt    = ifGnt;
  assign bus.d_gnt     = dGnt;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_we    = memWe;
  assign bus.mem_wdata = memWdata;

  assign bus.if_rvalid = (owner_q == OWN_FETCH);
  assign bus.if_err    = (owner_q == OWN_FETCH) && err_q;
  assign bus.if_rdata  = ((owner_q == OWN_FETCH) && !err_q) ? bus.mem_rdata : '0;

  assign bus.d_rvalid  = (owner_q == OWN_LOAD);
  assign bus.d_err     = ((owner_q == OWN_LOAD) || (owner_q == OWN_STORE)) && err_q;
  assign bus.d_rdata   = ((owner_q == OWN_LOAD) && !err_q) ? bus.mem_rdata : '0;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares the single-ported, word-organised main memory between the pipelined CPU's instruction-fetch port and data (load/store) port. It grants at most one access per cycle, drives the memory's address, write-data and write-enable lines, and routes the memory's registered read data back to the requester that owns it one cycle later. Out-of-range accesses are blocked. A starvation counter guarantees fetch progress under back-to-back data traffic.

## Interface
- DEPTH, 32, number of 32-bit words in the memory; valid word index 0..DEPTH-1
- STARVE_LIMIT, 4, consecutive denied fetch cycles after which fetch takes priority; legal range ≥1
- clk  in  1  system clock, rising edge
- n_rst  in  1  reset; asynchronous assert, active-low
- if_req  in  1  fetch request; held until granted
- if_addr  in  32  fetch byte address; bits [1:0] ignored
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid  out  1  fetch read data valid (registered)
- if_rdata  out  32  fetch read data
- if_err  out  1  fetch was out of range; valid with if_rvalid
- d_req  in  1  data request; held until granted
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address; bits [1:0] ignored
- d_wdata  in  32  store data
- d_gnt  out  1  data accepted this cycle (combinational)
- d_rvalid  out  1  load data valid (registered; loads only)
- d_rdata  out  32  load data
- d_err  out  1  data access out of range (registered pulse, loads and stores)
- mem_addr  out  32  byte address to memory
- mem_we  out  1  memory write strobe
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data; registered in memory, valid the cycle after mem_addr is presented

## Operation
- Word index = addr[31:2]. Out of range when index ≥ DEPTH.
- Arbitration each cycle:
  - d_req only → data.
  - if_req only → fetch.
  - Both → data, unless starve_cnt == STARVE_LIMIT, in which case fetch.
- starve_cnt is a saturating counter of width clog2(STARVE_LIMIT+1).
  - Increments when if_req=1 and if_gnt=0.
  - Clears when if_gnt=1 or if_req=0.
  - Never exceeds STARVE_LIMIT.
- Granted access drives mem_addr = requester address.
  - Granted in-range store: mem_we=1 and mem_wdata=d_wdata for that one cycle.
  - Out-of-range store: mem_we=0, so the write is suppressed.
  - No grant: mem_addr=0, mem_we=0, mem_wdata=0.
- Response tracking: a one-entry response register records owner (fetch / data-load / none) and the err bit for the access granted in cycle N.
  - Cycle N+1, fetch owner: if_rvalid=1, if_rdata = mem_rdata (0 if err), if_err = err.
  - Cycle N+1, data-load owner: d_rvalid=1, d_rdata = mem_rdata (0 if err).
  - Cycle N+1, data access that was out of range (load or store): d_err=1.
  - Stores never assert d_rvalid.
- rdata outputs are 0 whenever the matching rvalid is 0.
- Grants are not blocked by the in-flight response. Back-to-back grants every cycle are legal, giving full throughput.

## Timing
- Grant latency: 0 cycles (if_gnt/d_gnt combinational from requests and starve_cnt). Requester treats req & gnt at a rising edge as accepted.
- Read latency: 1 cycle from grant to rvalid.
- Store completes at the rising edge ending the grant cycle.
- Reset (n_rst low, any time, asynchronous):
  - starve_cnt=0 and response register = none.
  - if_rvalid, d_rvalid, if_err, d_err = 0; if_rdata, d_rdata = 0.
  - An in-flight response is dropped and never delivered.
  - Combinational outputs follow the requests, so requesters must hold req low during reset.
- Worst-case fetch wait under continuous data traffic: STARVE_LIMIT cycles, granted on cycle STARVE_LIMIT+1.

## Test plan
- Fetch only, memory word 4 = 0xc03f0003, if_req at if_addr 0x10 → if_gnt=1 same cycle, mem_addr=0x10; next cycle if_rvalid=1, if_rdata=0xc03f0003, if_err=0.
- if_req at 0x0 and d_req load at 0x8 together, word 2 = 0x38 → d_gnt=1, if_gnt=0. Next cycle: d_rvalid=1, d_rdata=0x38, and if_gnt=1 (fetch now alone or starve).
- d_req loads held 10 cycles with if_req held, STARVE_LIMIT=4 → if_gnt=0 for cycles 1–4, if_gnt=1 on cycle 5, starve_cnt returns to 0, d_gnt=1 on cycle 6.
- Store 0xdeadbeef at 0x40 → mem_we=1 one cycle, mem_wdata=0xdeadbeef, no d_rvalid, d_err=0. Load from 0x40 → d_rdata=0xdeadbeef.
- Store to 0x80 (index 32) → mem_we=0, d_err=1 next cycle, memory unchanged. Fetch at 0x100 → if_rvalid=1, if_rdata=0, if_err=1.
- Load granted, then n_rst pulsed low before the next edge → d_rvalid stays 0, all registered outputs 0. After release, a fresh fetch gets a normal 1-cycle response.
